// File: rtl/regtrace_streamer.sv
// regtrace_streamer: captures regfile writes as cycle-stamped records and
// streams them over valid/ready, then dumps all 32 registers via read port A.
//
// Parameters:
//   NUM_CYCLES : run length in cycles before the dump phase
//   CYC_W      : cycle stamp / counter width (NUM_CYCLES < 2**CYC_W)
//   FIFO_DEPTH : write-record FIFO entries (power of two, >= 2)
//
// Ports:
//   clock, reset    : clock and async active-low reset
//   rwe, rd, rData  : snooped regfile write port
//   test_mode       : selects rs1_test onto regfile read port A
//   rs1_test        : register index driven during the dump
//   regA            : regfile read port A data
//   out_valid/ready : output handshake
//   out_kind        : 0 = write record, 1 = dump record
//   out_cycle       : cycle stamp (0 on dump records)
//   out_reg         : register index
//   out_data        : register value
//   overflow        : sticky, a write record was dropped
//   done            : dump complete
//
// Optional build macro DUMP_SKIP_ZERO_EN: dump records whose register
// value is zero are not emitted.

module regtrace_streamer #(
  parameter int NUM_CYCLES = 255,
  parameter int CYC_W      = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rwe,
  input  logic [4:0]       rd,
  input  logic [31:0]      rData,
  output logic             test_mode,
  output logic [4:0]       rs1_test,
  input  logic [31:0]      regA,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [CYC_W-1:0] out_cycle,
  output logic [4:0]       out_reg,
  output logic [31:0]      out_data,
  output logic             overflow,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = CYC_W + 37;

  localparam logic [CYC_W-1:0] LAST =
    CYC_W'(NUM_CYCLES - 1);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       st_q, st_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic [RW-1:0]    mem_q [FIFO_DEPTH];

  logic             ov_q, ov_d;
  logic             kind_q, kind_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [4:0]       reg_q, reg_d;
  logic [31:0]      data_q, data_d;
  logic             ovf_q, ovf_d;

  logic          f_empty;
  logic          f_full;
  logic          xfer;
  logic          pop;
  logic          cap;
  logic          push;
  logic          drop;
  logic [RW-1:0] head;

  assign f_empty = (wp_q == rp_q);
  assign f_full  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign xfer = ov_q & out_ready;
  // Output register refills when empty or while
  // its current record is leaving.
  assign pop  = !f_empty && (!ov_q || xfer);
  assign cap  = (st_q == S_RUN) && rwe &&
                (rd != 5'd0);
  // A full FIFO still accepts when it pops in the
  // same cycle.
  assign push = cap && (!f_full || pop);
  assign drop = cap && f_full && !pop;
  assign head = mem_q[rp_q[AW-1:0]];

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    ov_d   = ov_q;
    kind_d = kind_q;
    cyc_d  = cyc_q;
    reg_d  = reg_q;
    data_d = data_q;
    ovf_d  = ovf_q | drop;

    if (push) wp_d = wp_q + (AW+1)'(1);
    if (pop)  rp_d = rp_q + (AW+1)'(1);

    if (xfer) ov_d = 1'b0;
    if (pop) begin
      ov_d   = 1'b1;
      kind_d = 1'b0;
      {cyc_d, reg_d, data_d} = head;
    end

    unique case (st_q)
      S_RUN: begin
        if (cnt_q == LAST) st_d = S_DRAIN;
        else cnt_d = cnt_q + CYC_W'(1);
      end
      S_DRAIN: begin
        if (f_empty && !ov_q) begin
          st_d  = S_ADDR;
          idx_d = 5'd0;
        end
      end
      S_ADDR: st_d = S_SEND;
      S_SEND: begin
        if (!ov_q) begin
`ifdef DUMP_SKIP_ZERO_EN
          if (regA == 32'd0) begin
            if (idx_q == 5'd31) begin
              st_d = S_DONE;
            end else begin
              idx_d = idx_q + 5'd1;
              st_d  = S_ADDR;
            end
          end else begin
            ov_d   = 1'b1;
            kind_d = 1'b1;
            cyc_d  = '0;
            reg_d  = idx_q;
            data_d = regA;
          end
`else
          ov_d   = 1'b1;
          kind_d = 1'b1;
          cyc_d  = '0;
          reg_d  = idx_q;
          data_d = regA;
`endif
        end else if (xfer) begin
          if (idx_q == 5'd31) begin
            st_d = S_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
            st_d  = S_ADDR;
          end
        end
      end
      S_DONE: st_d = S_DONE;
      default: st_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q   <= S_RUN;
      cnt_q  <= '0;
      idx_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      ov_q   <= 1'b0;
      kind_q <= 1'b0;
      cyc_q  <= '0;
      reg_q  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      ov_q   <= ov_d;
      kind_q <= kind_d;
      cyc_q  <= cyc_d;
      reg_q  <= reg_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q[AW-1:0]] <= {cnt_q, rd, rData};
  end

  assign test_mode = (st_q == S_ADDR) ||
                     (st_q == S_SEND) ||
                     (st_q == S_DONE);
  assign rs1_test  = ((st_q == S_ADDR) ||
                      (st_q == S_SEND)) ? idx_q : 5'd0;
  assign done      = (st_q == S_DONE);
  assign out_valid = ov_q;
  assign out_kind  = kind_q;
  assign out_cycle = cyc_q;
  assign out_reg   = reg_q;
  assign out_data  = data_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_regtrace_streamer.sv
// tb_regtrace_streamer: directed + random stimulus for regtrace_streamer,
// checked against a record-queue reference model.

module tb_regtrace_streamer;

  localparam int NC = 20;
  localparam int CW = 10;
  localparam int FD = 8;

  typedef struct packed {
    logic          kind;
    logic [CW-1:0] cyc;
    logic [4:0]    r;
    logic [31:0]   d;
  } rec_t;

  logic          clock;
  logic          reset;
  logic          rwe;
  logic [4:0]    rd;
  logic [31:0]   rData;
  logic          test_mode;
  logic [4:0]    rs1_test;
  logic [31:0]   regA;
  logic          out_valid;
  logic          out_ready;
  logic          out_kind;
  logic [CW-1:0] out_cycle;
  logic [4:0]    out_reg;
  logic [31:0]   out_data;
  logic          overflow;
  logic          done;

  regtrace_streamer #(
    .NUM_CYCLES(NC),
    .CYC_W(CW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rwe(rwe),
    .rd(rd),
    .rData(rData),
    .test_mode(test_mode),
    .rs1_test(rs1_test),
    .regA(regA),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_kind(out_kind),
    .out_cycle(out_cycle),
    .out_reg(out_reg),
    .out_data(out_data),
    .overflow(overflow),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] rf  [32];
  logic [31:0] mdl [32];
  rec_t expq[$];
  rec_t rxq[$];
  rec_t cur;
  rec_t prev;

  int nerr = 0;
  int nchk = 0;
  int k;
  int mode;
  int held;
  bit tog;
  bit hold;
  bit stall_cap;
  bit ovf_exp;

  assign regA = test_mode ?
    ((rs1_test == 5'd0) ? 32'd0 : rf[rs1_test]) :
    32'hDEAD_BEEF;
  assign cur = {out_kind, out_cycle, out_reg, out_data};

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'd0;
      mdl[i] = 32'd0;
    end
  endtask

  task automatic chk_zero(string tag);
    chk(tag, {test_mode, rs1_test, out_valid,
              out_kind, out_cycle, out_reg,
              out_data, overflow, done}, 64'd0);
  endtask

  // Drive one cycle's write and record its expected effect.
  task automatic wr(bit we, logic [4:0] r,
                    logic [31:0] d);
    rwe = we;
    rd = r;
    rData = d;
    if (we && r != 5'd0) begin
      mdl[r] = d;
      if (k < NC) begin
        if (stall_cap && held >= FD + 1) begin
          ovf_exp = 1'b1;
        end else begin
          expq.push_back(rec_t'({1'b0, CW'(k), r, d}));
          held++;
        end
      end
    end
  endtask

  task automatic tick();
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = tog;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    tog = ~tog;
    if (hold) chk("hold", {out_valid, cur}, {1'b1, prev});
    hold = out_valid && !out_ready;
    prev = cur;
    if (out_valid && out_ready) rxq.push_back(cur);
    @(posedge clock);
    @(negedge clock);
    if (rwe && rd != 5'd0) rf[rd] = rData;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rwe = 1'b0;
    rd = 5'd0;
    rData = 32'd0;
    out_ready = 1'b0;
    @(negedge clock);
    chk_zero("reset_outputs");
    reset = 1'b1;
    k = 0;
    hold = 1'b0;
    held = 0;
    ovf_exp = 1'b0;
    stall_cap = 1'b0;
    tog = 1'b1;
    rxq.delete();
    expq.delete();
  endtask

  task automatic finish_run();
    int n;
    logic [31:0] v;
    n = 0;
    wr(1'b0, 5'd0, 32'd0);
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'd0 : mdl[i];
`ifdef DUMP_SKIP_ZERO_EN
      if (v != 32'd0)
        expq.push_back(rec_t'({1'b1, CW'(0), 5'(i), v}));
`else
      expq.push_back(rec_t'({1'b1, CW'(0), 5'(i), v}));
`endif
    end
    chk("stream_len", rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rxq.size())
        chk($sformatf("rec%0d", i), rxq[i], expq[i]);
    end
    chk("overflow_end", overflow, ovf_exp);
    chk("done_outputs",
        {test_mode, rs1_test, out_valid}, {1'b1, 5'd0, 1'b0});
  endtask

  initial begin
    int nw;
    int n;
    int wcnt;
    logic [4:0] r;

    reset = 1'b0;
    rwe = 1'b0;
    rd = 5'd0;
    rData = 32'd0;
    out_ready = 1'b0;
    mode = 0;
    k = 0;
    tog = 1'b1;
    hold = 1'b0;
    held = 0;
    stall_cap = 1'b0;
    ovf_exp = 1'b0;
    clear_regs();
    @(negedge clock);

    // Directed: r0 write ignored, r1=5 @3, r2=-7 @4.
    do_reset();
    mode = 0;
    for (int c = 0; c < NC; c++) begin
      if (c == 2) wr(1'b1, 5'd0, 32'd99);
      else if (c == 3) wr(1'b1, 5'd1, 32'd5);
      else if (c == 4) wr(1'b1, 5'd2, 32'hFFFF_FFF9);
      else wr(1'b0, 5'd0, 32'd0);
      tick();
    end
    finish_run();
    chk("first_write", rxq[0],
        rec_t'({1'b0, CW'(3), 5'd1, 32'd5}));
    chk("second_write", rxq[1],
        rec_t'({1'b0, CW'(4), 5'd2, 32'hFFFF_FFF9}));
    chk("overflow_clean", overflow, 0);

    // Stalled receiver, 12 back-to-back writes.
    clear_regs();
    do_reset();
    mode = 3;
    stall_cap = 1'b1;
    for (int c = 0; c < NC; c++) begin
      chk("ovf_live", overflow, ovf_exp);
      if (c >= 1 && c <= 12)
        wr(1'b1, 5'(c), $urandom);
      else
        wr(1'b0, 5'd0, 32'd0);
      tick();
    end
    mode = 0;
    finish_run();
    nw = 0;
    foreach (rxq[i]) if (!rxq[i].kind) nw++;
    chk("nine_kept", nw, 9);
    chk("overflow_set", overflow, 1);

    // Random writes, toggled then random ready.
    for (int m = 1; m <= 2; m++) begin
      clear_regs();
      do_reset();
      mode = m;
      wcnt = 0;
      for (int c = 0; c < NC; c++) begin
        if (wcnt < 9 && $urandom_range(0, 1) == 1) begin
          r = 5'($urandom_range(0, 31));
          wr(1'b1, r, $urandom);
          if (r != 5'd0) wcnt++;
        end else begin
          wr(1'b0, 5'd0, 32'd0);
        end
        tick();
      end
      finish_run();
    end

    // Reset mid-dump at idx 12, then a fresh run.
    do_reset();
    mode = 0;
    for (int c = 0; c < NC; c++) begin
      if (c == 5) wr(1'b1, 5'd12, 32'h1234_5678);
      else wr(1'b0, 5'd0, 32'd0);
      tick();
    end
    n = 0;
    while (!(test_mode && rs1_test == 5'd12) && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_idx12", {test_mode, rs1_test}, {1'b1, 5'd12});
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clock);
    do_reset();
    mode = 0;
    for (int c = 0; c < NC; c++) begin
      if (c == 0) wr(1'b1, 5'd7, 32'hCAFE_0007);
      else if (c == NC - 1) wr(1'b1, 5'd3, 32'h33);
      else wr(1'b0, 5'd0, 32'd0);
      tick();
    end
    finish_run();
    chk("fresh_first", rxq[0],
        rec_t'({1'b0, CW'(0), 5'd7, 32'hCAFE_0007}));

    // Only r1 and r31 nonzero.
    clear_regs();
    do_reset();
    mode = 2;
    for (int c = 0; c < NC; c++) begin
      if (c == 1) wr(1'b1, 5'd1, 32'd5);
      else if (c == 2) wr(1'b1, 5'd31, 32'd9);
      else wr(1'b0, 5'd0, 32'd0);
      tick();
    end
    finish_run();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
